// File: rtl/row_fetch_scheduler_if.sv
// Fetch/swap control, host write port and frame RAM port of row_fetch_scheduler.
// slave = scheduler side; master = scan controller, host and RAM side.
interface row_fetch_scheduler_if #(
  parameter int PANELS = 4,
  parameter int LEDS   = 16,
  parameter int DATA_W = 24,
  parameter int ADDR_W = 10
);
  localparam int ROW_W = ADDR_W - $clog2(PANELS * LEDS);
  localparam int BUS_W = PANELS * LEDS * DATA_W;

  logic              fetch_req;
  logic [ROW_W-1:0]  fetch_row;
  logic              swap;
  logic              busy;
  logic              shadow_full;
  logic [BUS_W-1:0]  row_colors;
  logic              row_valid;
  logic              underrun;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  fetch_req, fetch_row, swap, wr_valid, wr_addr, wr_data, mem_rdata,
    output busy, shadow_full, row_colors, row_valid, underrun, wr_ready,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output fetch_req, fetch_row, swap, wr_valid, wr_addr, wr_data, mem_rdata,
    input  busy, shadow_full, row_colors, row_valid, underrun, wr_ready,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/row_fetch_scheduler.sv
// Fetches one cube row (64 words) into a shadow buffer and publishes it on swap; fetch takes 66..129 cycles.
// Host writes share the single RAM port round-robin with fetch reads, so a waiting host stalls at most 1 cycle.
module row_fetch_scheduler #(
  parameter int PANELS = 4,
  parameter int LEDS   = 16,
  parameter int DATA_W = 24,
  parameter int ADDR_W = 10
) (
  input logic                  i_clk,
  input logic                  i_reset,
  row_fetch_scheduler_if.slave io_bus
);
  localparam int WORDS   = PANELS * LEDS;
  localparam int K_W     = $clog2(WORDS);
  localparam int LED_W   = $clog2(LEDS);
  localparam int ROW_W   = ADDR_W - K_W;
  localparam int SLICE_W = LEDS * DATA_W;
  localparam int BUS_W   = PANELS * SLICE_W;
  localparam int IDX_W   = $clog2(BUS_W);
  localparam logic [K_W-1:0] K_LAST = K_W'(WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [K_W-1:0]     r_k;
  logic [K_W-1:0]     w_k_nxt;
  logic               r_host_turn;
  logic               w_host_turn_nxt;
  logic               w_host_grant;
  logic               w_read;
  logic               w_row_ld;
  logic               w_accept;
  logic               w_publish;
  logic [ROW_W-1:0]   r_row;
  logic               r_cap_vld;
  logic [K_W-1:0]     r_cap_k;
  logic [IDX_W-1:0]   w_cap_lsb;
  logic [ADDR_W-1:0]  w_rd_addr;
  logic [BUS_W-1:0]   r_shadow;
  logic [BUS_W-1:0]   r_row_colors;
  logic               r_shadow_full;
  logic               r_row_valid;
  logic               r_underrun;

  // A swap in the same cycle frees the shadow: it is published before the new fetch overwrites it.
  assign w_accept  = (r_state == S_IDLE) && io_bus.fetch_req && (!r_shadow_full || io_bus.swap);
  assign w_publish = io_bus.swap && r_shadow_full && (r_state == S_IDLE);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_host_turn <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_k         <= w_k_nxt;
      r_host_turn <= w_host_turn_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_k_nxt         = r_k;
    w_host_turn_nxt = r_host_turn;
    w_host_grant    = 1'b0;
    w_read          = 1'b0;
    w_row_ld        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_host_grant = io_bus.wr_valid;
        if (w_accept) begin
          w_state_nxt     = S_FETCH;
          w_k_nxt         = '0;
          w_host_turn_nxt = 1'b0;
          w_row_ld        = 1'b1;
        end
      end
      S_FETCH: begin
        if (r_host_turn && io_bus.wr_valid) begin
          w_host_grant    = 1'b1;
          w_host_turn_nxt = 1'b0;
        end else begin
          w_read          = 1'b1;
          w_host_turn_nxt = 1'b1;
          w_k_nxt         = r_k + 1'b1;
          if (r_k == K_LAST) w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_host_grant = io_bus.wr_valid;
        w_state_nxt  = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_rd_addr = {r_k[K_W-1:LED_W], r_row, r_k[LED_W-1:0]};

  assign io_bus.busy        = (r_state != S_IDLE);
  assign io_bus.wr_ready    = !i_reset && ((r_state != S_FETCH) || r_host_turn);
  assign io_bus.mem_en      = !i_reset && (w_host_grant || w_read);
  assign io_bus.mem_we      = !i_reset && w_host_grant;
  assign io_bus.mem_addr    = w_host_grant ? io_bus.wr_addr : w_rd_addr;
  assign io_bus.mem_wdata   = w_host_grant ? io_bus.wr_data : '0;
  assign io_bus.shadow_full = r_shadow_full;
  assign io_bus.row_colors  = r_row_colors;
  assign io_bus.row_valid   = r_row_valid;
  assign io_bus.underrun    = r_underrun;

  // Panel p occupies slice p; LED 0 sits in the slice MSBs.
  assign w_cap_lsb = IDX_W'(int'(r_cap_k[K_W-1:LED_W]) * SLICE_W
                            + (LEDS - 1 - int'(r_cap_k[LED_W-1:0])) * DATA_W);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_row         <= '0;
      r_cap_vld     <= 1'b0;
      r_cap_k       <= '0;
      r_shadow      <= '0;
      r_row_colors  <= '0;
      r_shadow_full <= 1'b0;
      r_row_valid   <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      if (w_row_ld) r_row <= io_bus.fetch_row;
      r_cap_vld   <= w_read;
      r_cap_k     <= r_k;
      if (r_cap_vld) r_shadow[w_cap_lsb +: DATA_W] <= io_bus.mem_rdata;
      r_row_valid <= w_publish;
      if (w_publish) r_row_colors <= r_shadow;
      if (io_bus.swap && !w_publish) r_underrun <= 1'b1;
      if (r_state == S_DRAIN) r_shadow_full <= 1'b1;
      else if (w_publish)     r_shadow_full <= 1'b0;
    end
  end
endmodule
